// File: rtl/bram_reader.sv
// bram_reader: BRAM fetch engine that loads the convolution kernel register and streams image pixels.
// Optional macro READ_DONE_EN adds a one-cycle read_done pulse when a read completes.
module bram_reader #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] KERNEL_ADDR = 32'h0000_0000,
   parameter logic [ADDR_WIDTH-1:0] IMAGE_ADDR  = 32'h0000_0024,
   parameter int                    PIXEL_SIZE  = 8,
   parameter int                    KERNEL_SIZE = 9,
   parameter int                    NUM_IMAGES  = 3,
   parameter int                    IMAGE_WORDS = 4
) (
   input  logic                                   clk,
   input  logic                                   reset,
   output logic [ADDR_WIDTH-1:0]                  bram_addr,
   input  logic [DATA_WIDTH-1:0]                  bram_data,
   input  logic                                   read_kernel,
   output logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] kernel,
   input  logic                                   read_image,
   output logic [PIXEL_SIZE-1:0]                  pixel,
   output logic                                   pixel_valid,
   input  logic                                   interrupt
`ifdef READ_DONE_EN
   ,
   output logic                                   read_done
`endif
);

   localparam int PPW         = DATA_WIDTH / PIXEL_SIZE;
   localparam int TOTAL_WORDS = NUM_IMAGES * IMAGE_WORDS;
   localparam int KCNT_W      = $clog2(KERNEL_SIZE + 1);
   localparam int WCNT_W      = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
   localparam int BCNT_W      = (PPW > 1) ? $clog2(PPW) : 1;
   localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

   typedef enum logic [2:0] {
      S_IDLE,
      S_KERNEL,
      S_IMG_ADDR,
      S_IMG_WAIT,
      S_IMG_EMIT
   } state_t;

   state_t                  state_reg, state_next;
   logic                    read_kernel_prev_reg, read_image_prev_reg;
   logic                    kernel_rise, image_rise;
   logic [KCNT_W-1:0]       kcnt_reg;
   logic [WCNT_W-1:0]       word_cnt_reg;
   logic [BCNT_W-1:0]       byte_cnt_reg;
   logic [DATA_WIDTH-1:0]   pixel_buf_reg;
   logic [PIXEL_SIZE-1:0]   buf_pixels [PPW];
   logic [KERNEL_SIZE-1:0]  kernel_we;

   genvar gi;

   generate
      for (gi = 0; gi < PPW; gi++) begin : g_buf_pixels
         assign buf_pixels[gi] = pixel_buf_reg[gi*PIXEL_SIZE +: PIXEL_SIZE];
      end
      // kcnt runs one ahead of the captured word because BRAM data lags the address by a cycle.
      for (gi = 0; gi < KERNEL_SIZE; gi++) begin : g_kernel_we
         assign kernel_we[gi] = (state_reg == S_KERNEL) && !interrupt &&
                                (kcnt_reg == KCNT_W'(gi + 1));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      kernel_rise = read_kernel & ~read_kernel_prev_reg;
      image_rise  = read_image & ~read_image_prev_reg;
      case (state_reg)
         S_IDLE: begin
            if (!interrupt) begin
               if (kernel_rise) begin
                  state_next = S_KERNEL;
               end else if (image_rise) begin
                  state_next = S_IMG_ADDR;
               end
            end
         end
         S_KERNEL: begin
            if (kcnt_reg == KCNT_W'(KERNEL_SIZE)) begin
               state_next = S_IDLE;
            end
         end
         S_IMG_ADDR: state_next = S_IMG_WAIT;
         S_IMG_WAIT: state_next = S_IMG_EMIT;
         S_IMG_EMIT: begin
            if (byte_cnt_reg == BCNT_W'(PPW - 1)) begin
               state_next = (word_cnt_reg == WCNT_W'(TOTAL_WORDS - 1)) ? S_IDLE : S_IMG_ADDR;
            end
         end
         default: state_next = S_IDLE;
      endcase
      if (interrupt && state_reg != S_IDLE) begin
         state_next = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         read_kernel_prev_reg <= 1'b0;
         read_image_prev_reg  <= 1'b0;
         bram_addr            <= '0;
         pixel                <= '0;
         pixel_valid          <= 1'b0;
         pixel_buf_reg        <= '0;
         kcnt_reg             <= '0;
         word_cnt_reg         <= '0;
         byte_cnt_reg         <= '0;
      end else begin
         read_kernel_prev_reg <= read_kernel;
         read_image_prev_reg  <= read_image;
         pixel_valid          <= (state_next == S_IMG_EMIT);
         case (state_reg)
            S_IDLE: begin
               if (state_next == S_KERNEL) begin
                  bram_addr <= KERNEL_ADDR;
                  kcnt_reg  <= '0;
               end else if (state_next == S_IMG_ADDR) begin
                  bram_addr    <= IMAGE_ADDR;
                  word_cnt_reg <= '0;
               end
            end
            S_KERNEL: begin
               if (state_next == S_KERNEL) begin
                  kcnt_reg <= kcnt_reg + KCNT_W'(1);
                  if (kcnt_reg < KCNT_W'(KERNEL_SIZE - 1)) begin
                     bram_addr <= bram_addr + WORD_STEP;
                  end
               end
            end
            S_IMG_WAIT: begin
               // Byte 0 goes straight out while the whole word is buffered for the rest.
               if (state_next == S_IMG_EMIT) begin
                  pixel_buf_reg <= bram_data;
                  pixel         <= bram_data[PIXEL_SIZE-1:0];
                  byte_cnt_reg  <= '0;
               end
            end
            S_IMG_EMIT: begin
               if (state_next == S_IMG_EMIT) begin
                  pixel        <= buf_pixels[byte_cnt_reg + BCNT_W'(1)];
                  byte_cnt_reg <= byte_cnt_reg + BCNT_W'(1);
               end else if (state_next == S_IMG_ADDR) begin
                  bram_addr    <= bram_addr + WORD_STEP;
                  word_cnt_reg <= word_cnt_reg + WCNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         kernel <= '0;
      end else begin
         for (int i = 0; i < KERNEL_SIZE; i++) begin
            if (kernel_we[i]) begin
               kernel[i] <= bram_data;
            end
         end
      end
   end

`ifdef READ_DONE_EN
   logic done_next;

   // Only a natural finish pulses; an interrupt in the final cycle counts as an abort.
   assign done_next = (state_next == S_IDLE) && !interrupt &&
                      ((state_reg == S_KERNEL) || (state_reg == S_IMG_EMIT));

   always_ff @(posedge clk) begin
      if (reset) begin
         read_done <= 1'b0;
      end else begin
         read_done <= done_next;
      end
   end
`endif

endmodule

// File: tb/tb_bram_reader.sv
// tb_bram_reader: self-checking bench for bram_reader with a byte-addressed BRAM model
// (byte at address b reads as b[7:0]) and an arithmetic model of the pixel stream timing.
module tb_bram_reader;

   localparam logic [31:0] KADDR = 32'h0000_0000;
   localparam logic [31:0] IADDR = 32'h0000_0024;
   localparam int          NPIX  = 48;

   logic                 clk;
   logic                 reset;
   logic [31:0]          bram_addr;
   logic [31:0]          bram_data;
   logic                 read_kernel;
   logic [8:0][31:0]     kernel;
   logic                 read_image;
   logic [7:0]           pixel;
   logic                 pixel_valid;
   logic                 interrupt;
`ifdef READ_DONE_EN
   logic                 read_done;
`endif

   int         n_vec;
   int         n_err;
   logic [7:0] last_pix;

   typedef struct {
      int          idx;
      logic [31:0] word;
   } kvec_t;

   kvec_t ktab [9];

   bram_reader dut (
      .clk         (clk),
      .reset       (reset),
      .bram_addr   (bram_addr),
      .bram_data   (bram_data),
      .read_kernel (read_kernel),
      .kernel      (kernel),
      .read_image  (read_image),
      .pixel       (pixel),
      .pixel_valid (pixel_valid),
      .interrupt   (interrupt)
`ifdef READ_DONE_EN
      ,
      .read_done   (read_done)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      logic [31:0] b;
      for (int k = 0; k < 4; k++) begin
         b = a + 32'(k);
         w[8*k +: 8] = b[7:0];
      end
      return w;
   endfunction

   always @(posedge clk) bram_data <= mem_word(bram_addr);

   function automatic int pix_time(input int j);
      return 3 + 6 * (j / 4) + (j % 4);
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_done(input string name, input logic exp);
`ifdef READ_DONE_EN
      check32(name, 32'(read_done), 32'(exp));
`endif
   endtask

   task automatic run_image(input int abort_at, input int width, input bit noise);
      int          t_abort;
      int          off;
      int          j;
      int          npix;
      logic        exp_valid;
      logic [31:0] pix_addr;
      t_abort = (abort_at > 0) ? pix_time(abort_at - 1) : 1000;
      npix    = 0;
      @(negedge clk);
      read_image = 1'b1;
      for (int t = 1; t <= 76; t++) begin
         @(negedge clk);
         exp_valid = 1'b0;
         off = t - 3;
         if (t <= t_abort && off >= 0 && off < 6 * (NPIX / 4) && (off % 6) < 4) begin
            exp_valid = 1'b1;
            j         = (off / 6) * 4 + (off % 6);
            pix_addr  = IADDR + 32'(j);
            last_pix  = pix_addr[7:0];
            npix++;
         end
         check32("pixel_valid", 32'(pixel_valid), 32'(exp_valid));
         check32("pixel", 32'(pixel), 32'(last_pix));
         if (t <= t_abort && (t - 1) % 6 == 0 && (t - 1) / 6 < NPIX / 4)
            check32("image bram_addr", bram_addr, IADDR + 32'(4 * ((t - 1) / 6)));
         check_done("image read_done", (abort_at == 0) && (t == 73));
         read_image = (t < width);
         interrupt  = (t == t_abort);
         read_kernel = (noise && t >= 2 && t < t_abort && t < 70) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      read_kernel = 1'b0;
      interrupt   = 1'b0;
      $display("image read: abort_after=%0d width=%0d noise=%0d pixels_expected=%0d",
               abort_at, width, noise, npix);
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      last_pix    = 8'h00;
      reset       = 1'b1;
      read_kernel = 1'b0;
      read_image  = 1'b0;
      interrupt   = 1'b0;

      ktab[0] = '{0, 32'h0302_0100};
      ktab[1] = '{1, 32'h0706_0504};
      ktab[2] = '{2, 32'h0b0a_0908};
      ktab[3] = '{3, 32'h0f0e_0d0c};
      ktab[4] = '{4, 32'h1312_1110};
      ktab[5] = '{5, 32'h1716_1514};
      ktab[6] = '{6, 32'h1b1a_1918};
      ktab[7] = '{7, 32'h1f1e_1d1c};
      ktab[8] = '{8, 32'h2322_2120};

      // Reset held for two edges.
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 9; i++) check32($sformatf("reset kernel[%0d]", i), kernel[i], 32'h0);
      check32("reset pixel_valid", 32'(pixel_valid), 32'h0);
      check32("reset bram_addr", bram_addr, 32'h0);
      check32("reset pixel", 32'(pixel), 32'h0);
      check_done("reset read_done", 1'b0);
      reset = 1'b0;
      $display("reset: checked reset values");

      // Kernel load with read_kernel held high well past completion: exactly one load.
      @(negedge clk);
      read_kernel = 1'b1;
      for (int t = 1; t <= 20; t++) begin
         @(negedge clk);
         check32("kernel bram_addr", bram_addr, KADDR + 32'(4 * ((t - 1 < 8) ? t - 1 : 8)));
         check_done("kernel read_done", t == 11);
         if (t == 10) check32("kernel[8] before done", kernel[8], 32'h0);
         if (t == 11) check32("kernel[8] at done", kernel[8], 32'h2322_2120);
         check32("kernel pixel_valid", 32'(pixel_valid), 32'h0);
         read_kernel = (t < 14);
      end
      for (int i = 0; i < 9; i++)
         check32($sformatf("kernel[%0d]", ktab[i].idx), kernel[ktab[i].idx], ktab[i].word);
      $display("kernel read: held high 14 cycles, 9 words checked");

      // Reset in the middle of a kernel load.
      @(negedge clk);
      read_kernel = 1'b1;
      for (int t = 1; t <= 15; t++) begin
         @(negedge clk);
         if (t == 5) begin
            for (int i = 0; i < 9; i++)
               check32($sformatf("midreset kernel[%0d]", i), kernel[i], 32'h0);
            check32("midreset pixel_valid", 32'(pixel_valid), 32'h0);
         end
         if (t >= 5) begin
            check32("midreset bram_addr", bram_addr, 32'h0);
            check_done("midreset read_done", 1'b0);
         end
         if (t == 2) read_kernel = 1'b0;
         reset = (t == 4) || (t == 5);
      end
      check32("midreset kernel any", 32'(|kernel), 32'h0);
      $display("kernel read: reset mid-load");

      // Interrupt during a kernel load keeps the words already captured.
      @(negedge clk);
      read_kernel = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         @(negedge clk);
         check_done("kabort read_done", 1'b0);
         read_kernel = 1'b0;
         interrupt   = (t == 5);
      end
      for (int i = 0; i < 3; i++)
         check32($sformatf("kabort kernel[%0d]", ktab[i].idx), kernel[ktab[i].idx], ktab[i].word);
      for (int i = 4; i < 9; i++)
         check32($sformatf("kabort kernel[%0d]", i), kernel[i], 32'h0);
      $display("kernel read: interrupt after 4 addresses");

      // Simultaneous edges: kernel wins, image request dropped.
      @(negedge clk);
      read_kernel = 1'b1;
      read_image  = 1'b1;
      for (int t = 1; t <= 16; t++) begin
         @(negedge clk);
         if (t == 1) check32("simul bram_addr", bram_addr, KADDR);
         check32("simul pixel_valid", 32'(pixel_valid), 32'h0);
         check_done("simul read_done", t == 11);
         if (t == 2) begin
            read_kernel = 1'b0;
            read_image  = 1'b0;
         end
      end
      for (int i = 0; i < 9; i++)
         check32($sformatf("simul kernel[%0d]", ktab[i].idx), kernel[ktab[i].idx], ktab[i].word);
      $display("simultaneous requests: kernel loaded, no pixels");

      run_image(0, 1, 1'b0);
      run_image(10, 2, 1'b0);
      run_image(0, 1, 1'b1);

      for (int r = 0; r < 5; r++) begin
         repeat ($urandom_range(1, 5)) @(negedge clk);
         run_image(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, NPIX)) : 0,
                   int'($urandom_range(1, 3)), 1'b1);
      end

      for (int i = 0; i < 9; i++)
         check32($sformatf("final kernel[%0d]", ktab[i].idx), kernel[ktab[i].idx], ktab[i].word);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
